// File: rtl/dbg_disp_ctrl_if.sv
// dbg_disp_ctrl_if: debug read port between the display controller and the CPU
interface dbg_disp_ctrl_if #(parameter int ADDR_W = 8);
   logic              dbg_req;
   logic              dbg_space;
   logic [ADDR_W-1:0] dbg_addr;
   logic              dbg_ack;
   logic [31:0]       dbg_rdata;
   modport master (output dbg_req, dbg_space, dbg_addr, input dbg_ack, dbg_rdata);
   modport slave  (input dbg_req, dbg_space, dbg_addr, output dbg_ack, dbg_rdata);
endinterface

// File: rtl/dbg_disp_ctrl.sv
// dbg_disp_ctrl: debounced address selection with periodic debug reads feeding the display
module dbg_disp_ctrl #(
   parameter int DB_CYCLES      = 1000000,
   parameter int REFRESH_CYCLES = 10000000,
   parameter int ADDR_W         = 8,
   parameter int TIMEOUT        = 255
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            btn_next,
   input  logic            btn_prev,
   input  logic            btn_mode,
   dbg_disp_ctrl_if.master dbg,
   output logic [31:0]     disp_data,
   output logic            led_space,
   output logic            timeout_err
);
   localparam int DB_W = $clog2(DB_CYCLES + 1);
   localparam int RF_W = $clog2(REFRESH_CYCLES + 1);
   localparam int WT_W = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W-1:0] REG_MAX = ADDR_W'(31);
   localparam logic [ADDR_W-1:0] MEM_MAX = '1;
   typedef enum logic {IDLE, REQ} state_t;
   state_t state, state_nx;
   logic [2:0] btn_raw, press;
   logic [ADDR_W-1:0] sel_addr, addr_max, addr_nx;
   logic sel_space, sel_chg, fetch_pending, wrap, req_nx, space_nx, terr_nx;
   logic [RF_W-1:0] ref_cnt;
   logic [WT_W-1:0] wait_cnt, wait_cnt_nx;
   logic [31:0] disp_nx;
   assign btn_raw = {btn_mode, btn_prev, btn_next};
   for (genvar i = 0; i < 3; i++) begin : g_db
      logic [1:0] sync;
      logic level, flip;
      logic [DB_W-1:0] cnt;
      assign flip = (sync[1] != level) && (cnt == DB_W'(DB_CYCLES - 1));
      assign press[i] = flip && !level;
      always_ff @(posedge clk or negedge rstn)
         if (!rstn) begin
            sync  <= '0;
            level <= 1'b0;
            cnt   <= '0;
         end else begin
            sync  <= {sync[0], btn_raw[i]};
            level <= level ^ flip;
            cnt   <= (sync[1] == level || flip) ? '0 : cnt + 1'b1;
         end
   end
   assign addr_max  = sel_space ? MEM_MAX : REG_MAX;
   assign sel_chg   = press[2] | (press[0] ^ press[1]);
   assign wrap      = ref_cnt == RF_W'(REFRESH_CYCLES - 1);
   assign led_space = sel_space;
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         sel_space     <= 1'b0;
         sel_addr      <= '0;
         ref_cnt       <= '0;
         fetch_pending <= 1'b1;
      end else begin
         if (press[2]) begin
            sel_space <= ~sel_space;
            sel_addr  <= '0;
         end else if (press[0] && !press[1])
            sel_addr <= (sel_addr == addr_max) ? '0 : sel_addr + 1'b1;
         else if (press[1] && !press[0])
            sel_addr <= (sel_addr == '0) ? addr_max : sel_addr - 1'b1;
         ref_cnt       <= wrap ? '0 : ref_cnt + 1'b1;
         fetch_pending <= sel_chg | wrap | (fetch_pending & (state != IDLE));
      end
   always_comb begin
      state_nx    = state;
      req_nx      = dbg.dbg_req;
      space_nx    = dbg.dbg_space;
      addr_nx     = dbg.dbg_addr;
      disp_nx     = disp_data;
      terr_nx     = timeout_err;
      wait_cnt_nx = wait_cnt;
      if (state == IDLE) begin
         if (fetch_pending) begin
            state_nx    = REQ;
            req_nx      = 1'b1;
            space_nx    = sel_space;
            addr_nx     = sel_addr;
            wait_cnt_nx = '0;
         end
      end else if (dbg.dbg_ack) begin
         state_nx = IDLE;
         req_nx   = 1'b0;
         disp_nx  = dbg.dbg_rdata;
         terr_nx  = 1'b0;
      end else if (wait_cnt == WT_W'(TIMEOUT - 1)) begin
         state_nx = IDLE;
         req_nx   = 1'b0;
         disp_nx  = 32'hDEAD_DEAD;
         terr_nx  = 1'b1;
      end else
         wait_cnt_nx = wait_cnt + 1'b1;
   end
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         state         <= IDLE;
         dbg.dbg_req   <= 1'b0;
         dbg.dbg_space <= 1'b0;
         dbg.dbg_addr  <= '0;
         disp_data     <= '0;
         timeout_err   <= 1'b0;
         wait_cnt      <= '0;
      end else begin
         state         <= state_nx;
         dbg.dbg_req   <= req_nx;
         dbg.dbg_space <= space_nx;
         dbg.dbg_addr  <= addr_nx;
         disp_data     <= disp_nx;
         timeout_err   <= terr_nx;
         wait_cnt      <= wait_cnt_nx;
      end
endmodule

// File: tb/tb_dbg_disp_ctrl.sv
// tb_dbg_disp_ctrl: directed and randomized checks of dbg_disp_ctrl against a behavioural model
module tb_dbg_disp_ctrl;
   localparam int DB = 4, RF = 64, AW = 8, TO = 15;
   logic clk = 0, rstn = 1;
   logic btn_next = 0, btn_prev = 0, btn_mode = 0;
   logic [31:0] disp_data;
   logic led_space, timeout_err;
   int tests = 0, fails = 0;
   dbg_disp_ctrl_if #(.ADDR_W(AW)) dbg ();
   dbg_disp_ctrl #(.DB_CYCLES(DB), .REFRESH_CYCLES(RF), .ADDR_W(AW), .TIMEOUT(TO)) dut (
      .clk(clk), .rstn(rstn), .btn_next(btn_next), .btn_prev(btn_prev), .btn_mode(btn_mode),
      .dbg(dbg), .disp_data(disp_data), .led_space(led_space), .timeout_err(timeout_err));
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask
   // responder: ack_delay 0 means never ack; otherwise ack on the Nth cycle dbg_req is seen high
   int ack_delay = 2, cur_delay = 2, age = 0;
   bit rand_delay = 0, spurious = 0, use_fixed = 1;
   logic [31:0] fixed_data = 32'h1234_5678, last_rdata = 0;
   always @(negedge clk) begin
      if (dbg.dbg_req) begin
         if (age == 0) cur_delay = rand_delay ? int'($urandom_range(1, 17)) : ack_delay;
         age++;
      end else age = 0;
      if (dbg.dbg_req && cur_delay != 0 && age >= cur_delay) begin
         dbg.dbg_ack = 1;
         dbg.dbg_rdata = use_fixed ? fixed_data : $urandom;
         last_rdata = dbg.dbg_rdata;
      end else begin
         dbg.dbg_ack = spurious && !dbg.dbg_req && ($urandom_range(0, 3) == 0);
         dbg.dbg_rdata = $urandom;
      end
   end
   int rises = 0, req_len = 0, last_len = 0;
   logic [AW-1:0] last_addr = 0;
   logic last_space = 0, prev_req = 0;
   always @(negedge clk) begin
      if (dbg.dbg_req === 1'b1 && prev_req !== 1'b1) begin
         rises++;
         last_addr = dbg.dbg_addr;
         last_space = dbg.dbg_space;
         req_len = 0;
      end
      if (dbg.dbg_req === 1'b1) req_len++;
      else if (prev_req === 1'b1) last_len = req_len;
      prev_req = dbg.dbg_req;
   end
   // model: debounce as "last DB synchronised samples all opposite", selection by modular arithmetic
   logic [15:0] rh [3];
   logic m_db [3];
   bit m_pr [3];
   bit busy, pend, m_sp, e_req, e_sp, e_terr, wrap, chg, all_diff;
   int ec, waited, m_addr, e_addr, size;
   logic [31:0] e_disp;
   logic [2:0] raw;
   assign raw = {btn_mode, btn_prev, btn_next};
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int b = 0; b < 3; b++) begin
            rh[b] = '0;
            m_db[b] = 0;
            m_pr[b] = 0;
         end
         ec = 0; busy = 0; pend = 1; m_sp = 0; m_addr = 0; waited = 0;
         e_req = 0; e_sp = 0; e_addr = 0; e_terr = 0; e_disp = 0;
      end else begin
         for (int b = 0; b < 3; b++) begin
            all_diff = 1;
            for (int j = 1; j <= DB; j++) if (rh[b][j] == m_db[b]) all_diff = 0;
            m_pr[b] = all_diff && !m_db[b];
            if (all_diff) m_db[b] = !m_db[b];
            rh[b] = {rh[b][14:0], raw[b]};
         end
         wrap = (ec % RF) == RF - 1;
         ec++;
         if (!busy) begin
            if (pend) begin
               busy = 1; pend = 0; e_req = 1; e_sp = m_sp; e_addr = m_addr; waited = 0;
            end
         end else if (dbg.dbg_ack) begin
            busy = 0; e_req = 0; e_disp = dbg.dbg_rdata; e_terr = 0;
         end else begin
            waited++;
            if (waited == TO) begin
               busy = 0; e_req = 0; e_disp = 32'hDEAD_DEAD; e_terr = 1;
            end
         end
         chg = m_pr[2] || (m_pr[0] != m_pr[1]);
         size = m_sp ? (1 << AW) : 32;
         if (m_pr[2]) begin
            m_sp = !m_sp;
            m_addr = 0;
         end else if (m_pr[0] && !m_pr[1]) m_addr = (m_addr + 1) % size;
         else if (m_pr[1] && !m_pr[0]) m_addr = (m_addr + size - 1) % size;
         if (chg || wrap) pend = 1;
      end
   end
   bit chk_en = 0;
   always @(negedge clk) if (chk_en) begin
      check("dbg_req", dbg.dbg_req, e_req);
      check("dbg_space", dbg.dbg_space, e_sp);
      check("dbg_addr", dbg.dbg_addr, e_addr);
      check("disp_data", disp_data, e_disp);
      check("led_space", led_space, m_sp);
      check("timeout_err", timeout_err, e_terr);
   end
   task automatic step(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask
   task automatic set_btn(input int b, input logic v);
      if (b == 0) btn_next = v;
      else if (b == 1) btn_prev = v;
      else btn_mode = v;
   endtask
   task automatic press(input int b, input int hi, input int lo);
      set_btn(b, 1); step(hi); set_btn(b, 0); step(lo);
   endtask
   task automatic wait_fall(input string name, input int limit);
      int n = 0;
      while (dbg.dbg_req && n < limit) begin step(); n++; end
      check(name, dbg.dbg_req, 0);
   endtask
   task automatic wait_rise(input string name, input int limit);
      int r = rises, n = 0;
      while (rises == r && n < limit) begin step(); n++; end
      check(name, rises != r, 1);
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1);
   end
   initial begin
      int r0, n;
      int hold [3] = '{0, 0, 0};
      step(1);
      rstn = 0; step(1); chk_en = 1; step(2);
      rstn = 1; step(1);
      check("post_reset_req", dbg.dbg_req, 1);
      check("post_reset_addr", dbg.dbg_addr, 0);
      check("post_reset_space", dbg.dbg_space, 0);
      wait_fall("post_reset_fall", 10);
      check("post_reset_disp", disp_data, 32'h1234_5678);
      check("post_reset_terr", timeout_err, 0);
      use_fixed = 0; ack_delay = 3;
      for (int i = 0; i < 3; i++) begin btn_next = 1; step(2); btn_next = 0; step(2); end
      press(0, 10, 12);
      wait_fall("bounce_idle", 40);
      check("bounce_addr", last_addr, 1);
      press(0, 3, 12);
      wait_fall("short_idle", 40);
      check("short_press_addr", last_addr, 1);
      press(1, 6, 12); wait_fall("prev_idle", 40);
      check("prev_addr", last_addr, 0);
      press(1, 6, 12); wait_fall("wrap_reg_idle", 40);
      check("wrap_reg_addr", last_addr, 31);
      check("wrap_reg_space", last_space, 0);
      press(2, 6, 12); wait_fall("mode_idle", 40);
      check("mode_space", last_space, 1);
      check("mode_addr", last_addr, 0);
      check("mode_led", led_space, 1);
      press(1, 6, 12); wait_fall("wrap_mem_idle", 40);
      check("wrap_mem_addr", last_addr, 255);
      check("model_mem_addr", m_addr, 255);
      ack_delay = 0;
      wait_fall("to_idle", 40);
      wait_rise("to_rise", 80);
      wait_fall("to_fall", 30);
      check("to_len", last_len, 15);
      check("to_disp", disp_data, 32'hDEAD_DEAD);
      check("to_terr", timeout_err, 1);
      check("model_to_terr", e_terr, 1);
      ack_delay = 3; use_fixed = 1; fixed_data = 32'hCAFE_F00D;
      wait_rise("rec_rise", 80);
      wait_fall("rec_fall", 30);
      check("rec_terr", timeout_err, 0);
      check("rec_disp", disp_data, 32'hCAFE_F00D);
      use_fixed = 0; ack_delay = 15;
      n = 0;
      while (!((ec % RF) == 50 && !dbg.dbg_req) && n < 200) begin step(); n++; end
      check("coal_sync", n < 200, 1);
      r0 = rises;
      press(1, 4, 0);
      press(0, 4, 0);
      check("coal_first_addr", dbg.dbg_addr, 254);
      step(4);
      press(0, 4, 0);
      step(45);
      check("coal_rises", rises - r0, 2);
      check("coal_addr", last_addr, 0);
      check("coal_ack_wins", timeout_err, 0);
      check("coal_disp", disp_data, last_rdata);
      ack_delay = 0;
      wait_rise("rst_rise", 80);
      step(3);
      #2 rstn = 0;
      #1;
      check("rst_req", dbg.dbg_req, 0);
      check("rst_disp", disp_data, 0);
      check("rst_led", led_space, 0);
      check("rst_terr", timeout_err, 0);
      step(2);
      rstn = 1; step(1);
      check("rst_fetch_req", dbg.dbg_req, 1);
      check("rst_fetch_addr", dbg.dbg_addr, 0);
      check("rst_fetch_space", dbg.dbg_space, 0);
      rand_delay = 1; spurious = 1;
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 3; b++)
            if (hold[b] == 0) begin
               set_btn(b, 1'($urandom_range(0, 1)));
               hold[b] = $urandom_range(1, 9);
            end else hold[b]--;
         step(1);
      end
      chk_en = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/dbg_disp_ctrl.md
Name: dbg_disp_ctrl

Overview:
- Debug-display controller that sits directly upstream of the 8-digit seven-segment driver.
- Three push-buttons select a CPU register index or a data-memory word address; each button is synchronised and debounced.
- The block reads the selected location over the CPU debug read port using a req/ack handshake.
- It holds the returned 32-bit word on disp_data, which drives the segment driver's data input, and refreshes it periodically so live values track the running CPU.

Parameters:
- DB_CYCLES, 1000000: consecutive stable samples required to accept a button level change (10 ms at 100 MHz).
- REFRESH_CYCLES, 10000000: period between automatic re-reads (100 ms at 100 MHz).
- ADDR_W, 8: width of dbg_addr. Memory space uses the full 0..2^ADDR_W-1 word range.
- TIMEOUT, 255: maximum cycles dbg_req may wait for dbg_ack.

Ports:
- clk  in  1  system clock
- rstn  in  1  reset
- btn_next  in  1  raw button: increment address
- btn_prev  in  1  raw button: decrement address
- btn_mode  in  1  raw button: toggle register/memory space
- dbg_req  out  1  debug read request
- dbg_space  out  1  0 = register file, 1 = data memory
- dbg_addr  out  ADDR_W  debug read address
- dbg_ack  in  1  debug read acknowledge; dbg_rdata is valid in the same cycle
- dbg_rdata  in  32  debug read data
- disp_data  out  32  word shown on the seven-segment display
- led_space  out  1  current selected space, for an LED
- timeout_err  out  1  sticky flag: the last read timed out

Behaviour:
- Reset: already decided — reset rstn, asynchronous, active-low; clock clk.
  - All registers clear on reset: disp_data=0, dbg_req=0, dbg_space=0, dbg_addr=0, led_space=0, timeout_err=0, sel_addr=0, refresh counter=0, debounce state=released.
  - fetch_pending is set to 1 on reset, so the first read starts immediately after reset deasserts.
- Debounce, per button:
  - 2-FF synchroniser, then a counter that increments while the synchronised level differs from the debounced level and clears otherwise.
  - When the counter reaches DB_CYCLES-1, the debounced level flips.
  - A debounced 0->1 transition produces a 1-cycle press pulse. Release produces no pulse.
- Selection (sel_space, sel_addr), updated in any FSM state:
  - mode pulse: toggle sel_space and set sel_addr=0. Mode has priority over next/prev in the same cycle.
  - next and prev pulses in the same cycle: no change.
  - next: increment with wrap. Register space wraps 31->0; memory space wraps 2^ADDR_W-1 -> 0.
  - prev: decrement with wrap. Register space wraps 0->31; memory space wraps 0 -> 2^ADDR_W-1.
  - Any selection change sets fetch_pending.
  - led_space = sel_space, registered.
- Refresh counter:
  - Free-running from 0 to REFRESH_CYCLES-1, then wraps to 0.
  - On wrap it sets fetch_pending.
  - It is not reset by button presses.
- FSM IDLE:
  - If fetch_pending: capture dbg_space<=sel_space and dbg_addr<=sel_addr, assert dbg_req, clear fetch_pending, clear the wait counter, go to REQ.
- FSM REQ:
  - dbg_req, dbg_space and dbg_addr are held stable.
  - On dbg_ack: disp_data<=dbg_rdata on the same edge, dbg_req<=0, timeout_err<=0, go to IDLE.
  - Otherwise increment the wait counter. When it reaches TIMEOUT: dbg_req<=0, disp_data<=32'hDEAD_DEAD, timeout_err<=1, go to IDLE.
  - An ack arriving on the same edge as the timeout takes precedence: the data is latched.
- Latency:
  - Trigger to dbg_req=1 is 1 cycle.
  - Ack to updated disp_data is 1 edge.
  - A pending fetch that arrives during REQ starts in the cycle after the return to IDLE.
  - Multiple triggers during REQ coalesce into one fetch.
- dbg_ack while in IDLE is ignored.
- Reset mid-operation aborts the request: dbg_req drops asynchronously and a fresh fetch of register 0 follows.

Test Plan (DB_CYCLES=4, REFRESH_CYCLES=64, ADDR_W=8, TIMEOUT=15):
- Post-reset fetch:
  - Stimulus: release rstn; responder acks after 2 cycles with 32'h1234_5678.
  - Required: dbg_req rises 1 cycle after reset with space=0, addr=0; disp_data=32'h1234_5678 one edge after ack; timeout_err=0.
- Debounce:
  - Stimulus: btn_next bounces with 2-cycle pulses, then is held 10 cycles.
  - Required: exactly one increment to sel_addr=1; next fetch shows dbg_addr=1.
  - Stimulus: a 3-cycle press.
  - Required: no increment.
- Wrap:
  - Stimulus: prev at register addr 0.
  - Required: dbg_addr=31.
  - Stimulus: mode press.
  - Required: dbg_space=1, dbg_addr=0, led_space=1.
  - Stimulus: prev in memory space at addr 0.
  - Required: dbg_addr=255.
- Timeout:
  - Stimulus: responder never acks.
  - Required: dbg_req high for exactly 15 cycles, then 0; disp_data=32'hDEADDEAD; timeout_err=1.
  - Stimulus: next successful read.
  - Required: timeout_err clears.
- Coalescing:
  - Stimulus: next pressed twice plus a refresh wrap while in REQ.
  - Required: exactly one follow-up request, with dbg_addr equal to the final sel_addr.
- Async reset in REQ:
  - Stimulus: assert rstn=0 mid-request.
  - Required: dbg_req=0 and disp_data=0 immediately; after release, a fetch of register 0 is issued.
